// File: rtl/serializer_sched.sv
// Frame scheduler ahead of serializer_in: data FIFO plus a single-entry
// priority control slot, fixed-priority arbitration, one start pulse per
// frame, end-of-transfer wait with timeout abort, and optional idle-comma fill.
module serializer_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          IDLE_FILL = 1'b1,
  parameter logic [26:0] IDLE_WORD = 27'h17C_BC_BC,
  parameter int unsigned GAP_CYC   = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       wr_valid_i,
  input  logic [26:0]                wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       ctl_valid_i,
  input  logic [26:0]                ctl_data_i,
  output logic                       ctl_ready_o,
  output logic                       ser_start_o,
  output logic [31:0]                ser_data_o,
  input  logic                       ser_eot_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [15:0]                sent_cnt_o,
  output logic                       err_o,
  input  logic                       err_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  // GAP lasts at least one cycle even when GAP_CYC is zero.
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC == 0) ? '0 : GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_EOT,
    S_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [26:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ctl_full_q, ctl_full_d;
  logic [26:0]     ctl_data_q, ctl_data_d;
  logic [26:0]     data_q, data_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [15:0]     sent_q, sent_d;
  logic            err_q, err_d;
  logic            eot_q;

  logic            push;
  logic            pop_fifo;
  logic            pop_ctl;
  logic            err_set;
  logic            eot_rise;

  assign wr_ready_o  = (level_q != DEPTH_L);
  assign ctl_ready_o = ~ctl_full_q;
  assign ser_start_o = (state_q == S_LAUNCH);
  assign busy_o      = (state_q != S_IDLE);
  assign ser_data_o  = {5'b0, data_q};
  assign level_o     = level_q;
  assign sent_cnt_o  = sent_q;
  assign err_o       = err_q;

  assign push     = wr_valid_i & wr_ready_o;
  assign eot_rise = ser_eot_i & ~eot_q;

  // Scheduler next-state: source arbitration, eot/timeout wait, gap timing.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    sent_d   = sent_q;
    err_set  = 1'b0;
    pop_fifo = 1'b0;
    pop_ctl  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          if (ctl_full_q) begin
            data_d  = ctl_data_q;
            pop_ctl = 1'b1;
            state_d = S_LAUNCH;
          end else if (level_q != '0) begin
            data_d   = mem[rd_ptr_q];
            pop_fifo = 1'b1;
            state_d  = S_LAUNCH;
          end else if (IDLE_FILL) begin
            data_d  = IDLE_WORD;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        tmo_d   = '0;
        state_d = S_WAIT_EOT;
      end
      S_WAIT_EOT: begin
        // An eot edge arriving on the timeout cycle still counts as delivered.
        if (eot_rise) begin
          sent_d  = sent_q + 16'd1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  // FIFO pointers/occupancy and control-slot next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ctl_full_d = ctl_full_q;
    ctl_data_d = ctl_data_q;
    if (push)     wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fifo) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop_fifo})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (pop_ctl) ctl_full_d = 1'b0;
    // Slot only accepts when empty, so load and pop never coincide.
    if (ctl_valid_i && !ctl_full_q) begin
      ctl_full_d = 1'b1;
      ctl_data_d = ctl_data_i;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ctl_full_q <= 1'b0;
      ctl_data_q <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      sent_q     <= '0;
      err_q      <= 1'b0;
      eot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ctl_full_q <= ctl_full_d;
      ctl_data_q <= ctl_data_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      eot_q      <= ser_eot_i;
    end
  end

endmodule

// File: tb/tb_serializer_sched.sv
// Directed self-checking bench for serializer_sched: a cycle-exact vector
// table for the basic flow, then hand-written multi-cycle sequences.
module tb_serializer_sched;

  localparam int unsigned TMO   = 32;
  localparam int unsigned GAPC  = 2;
  localparam logic [26:0] IDLEW = 27'h17C_BC_BC;
  localparam logic [26:0] FA    = 27'h0123456;
  localparam logic [26:0] FB    = 27'h7654321;
  localparam logic [26:0] FC    = 27'h1BC0055;
  localparam int          WMAX  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, wv = 1'b0, cv = 1'b0, eot = 1'b0, clr = 1'b0;
  logic [26:0] wd = '0, cd = '0;
  logic        wrdy, crdy, start, busy, err;
  logic [31:0] sdata;
  logic [3:0]  lvl;
  logic [15:0] sent;

  logic        b_eot = 1'b0;
  logic        b_wrdy, b_crdy, b_start, b_busy, b_err;
  logic [31:0] b_sdata;
  logic [3:0]  b_lvl;
  logic [15:0] b_sent;

  int checks = 0;
  int errors = 0;
  int exp_sent = 0;

  always #5 clk = ~clk;

  serializer_sched #(.DEPTH(8), .IDLE_FILL(1'b0), .IDLE_WORD(IDLEW),
                     .GAP_CYC(GAPC), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en),
    .wr_valid_i(wv), .wr_data_i(wd), .wr_ready_o(wrdy),
    .ctl_valid_i(cv), .ctl_data_i(cd), .ctl_ready_o(crdy),
    .ser_start_o(start), .ser_data_o(sdata), .ser_eot_i(eot),
    .busy_o(busy), .level_o(lvl), .sent_cnt_o(sent),
    .err_o(err), .err_clr_i(clr)
  );

  serializer_sched #(.DEPTH(8), .IDLE_FILL(1'b1), .IDLE_WORD(IDLEW),
                     .GAP_CYC(GAPC), .TIMEOUT(TMO)) dut_fill (
    .clk_i(clk), .rst_i(rst_n), .enable_i(1'b1),
    .wr_valid_i(1'b0), .wr_data_i(27'h0), .wr_ready_o(b_wrdy),
    .ctl_valid_i(1'b0), .ctl_data_i(27'h0), .ctl_ready_o(b_crdy),
    .ser_start_o(b_start), .ser_data_o(b_sdata), .ser_eot_i(b_eot),
    .busy_o(b_busy), .level_o(b_lvl), .sent_cnt_o(b_sent),
    .err_o(b_err), .err_clr_i(1'b0)
  );

  typedef struct {
    logic        en, wv;
    logic [26:0] wd;
    logic        cv, eot;
    logic        st;
    logic [26:0] dat;
    logic        busy;
    logic [3:0]  lvl;
    logic        crdy;
    logic [15:0] sent;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t v(input logic e, input logic w, input logic [26:0] d,
                             input logic c, input logic t, input logic s,
                             input logic [26:0] x, input logic b, input logic [3:0] l,
                             input logic r, input logic [15:0] n);
    vec_t o;
    o.en = e; o.wv = w; o.wd = d; o.cv = c; o.eot = t;
    o.st = s; o.dat = x; o.busy = b; o.lvl = l; o.crdy = r; o.sent = n;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [26:0] d);
    wv = 1'b1; wd = d;
    step();
    wv = 1'b0;
  endtask

  task automatic wait_start(input logic [26:0] exp, input string nm);
    int n = 0;
    while (!start && n < WMAX) begin
      step();
      n++;
    end
    chk({nm, ".start_seen"}, {31'b0, start}, 32'd1);
    chk({nm, ".data"}, sdata, {5'b0, exp});
  endtask

  task automatic do_eot(input int dly, input string nm);
    repeat (dly) step();
    eot = 1'b1;
    step();
    eot = 1'b0;
    exp_sent++;
    chk({nm, ".sent"}, {16'b0, sent}, exp_sent);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".start"}, {31'b0, start}, 32'd0);
    chk({nm, ".data"},  sdata, 32'd0);
    chk({nm, ".busy"},  {31'b0, busy}, 32'd0);
    chk({nm, ".level"}, {28'b0, lvl}, 32'd0);
    chk({nm, ".wr_ready"}, {31'b0, wrdy}, 32'd1);
    chk({nm, ".ctl_ready"}, {31'b0, crdy}, 32'd1);
    chk({nm, ".sent"}, {16'b0, sent}, 32'd0);
    chk({nm, ".err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    logic [26:0] fr [8];
    int n;

    tbl[0]  = v(1,1,FA,0,0, 0,27'h0,0,4'd1,1,16'd0);
    tbl[1]  = v(1,1,FB,0,0, 1,FA,1,4'd1,1,16'd0);
    tbl[2]  = v(1,0,27'h0,0,0, 0,FA,1,4'd1,1,16'd0);
    tbl[3]  = v(1,0,27'h0,0,1, 0,FA,1,4'd1,1,16'd1);
    tbl[4]  = v(1,0,27'h0,0,1, 0,FA,1,4'd1,1,16'd1);
    tbl[5]  = v(1,0,27'h0,0,0, 0,FA,0,4'd1,1,16'd1);
    tbl[6]  = v(1,0,27'h0,0,0, 1,FB,1,4'd0,1,16'd1);
    tbl[7]  = v(1,0,27'h0,0,0, 0,FB,1,4'd0,1,16'd1);
    tbl[8]  = v(1,0,27'h0,0,0, 0,FB,1,4'd0,1,16'd1);
    tbl[9]  = v(1,0,27'h0,0,1, 0,FB,1,4'd0,1,16'd2);
    tbl[10] = v(1,0,27'h0,0,0, 0,FB,1,4'd0,1,16'd2);
    tbl[11] = v(1,0,27'h0,0,0, 0,FB,0,4'd0,1,16'd2);
    tbl[12] = v(1,0,27'h0,1,0, 0,FB,0,4'd0,0,16'd2);
    tbl[13] = v(0,0,27'h0,0,1, 0,FB,0,4'd0,0,16'd2);
    tbl[14] = v(1,0,27'h0,0,1, 1,FC,1,4'd0,1,16'd2);
    tbl[15] = v(1,0,27'h0,0,1, 0,FC,1,4'd0,1,16'd2);
    tbl[16] = v(1,0,27'h0,0,1, 0,FC,1,4'd0,1,16'd2);
    tbl[17] = v(1,0,27'h0,0,0, 0,FC,1,4'd0,1,16'd2);
    tbl[18] = v(1,0,27'h0,0,1, 0,FC,1,4'd0,1,16'd3);
    tbl[19] = v(1,0,27'h0,0,0, 0,FC,1,4'd0,1,16'd3);
    tbl[20] = v(1,0,27'h0,0,0, 0,FC,0,4'd0,1,16'd3);

    // Reset values
    repeat (3) step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    en = 1'b1;
    repeat (2) step();
    chk("post_reset.busy", {31'b0, busy}, 32'd0);

    // Cycle-exact table: push/launch latency, eot edge handling, ctl slot, enable hold
    cd = FC;
    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; wv = tbl[i].wv; wd = tbl[i].wd;
      cv = tbl[i].cv; eot = tbl[i].eot;
      step();
      chk($sformatf("tbl[%0d].start", i), {31'b0, start}, {31'b0, tbl[i].st});
      chk($sformatf("tbl[%0d].data", i), sdata, {5'b0, tbl[i].dat});
      chk($sformatf("tbl[%0d].busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
      chk($sformatf("tbl[%0d].level", i), {28'b0, lvl}, {28'b0, tbl[i].lvl});
      chk($sformatf("tbl[%0d].ctl_ready", i), {31'b0, crdy}, {31'b0, tbl[i].crdy});
      chk($sformatf("tbl[%0d].sent", i), {16'b0, sent}, {16'b0, tbl[i].sent});
    end
    wv = 1'b0; cv = 1'b0; eot = 1'b0; en = 1'b1;
    exp_sent = 3;

    // Control frame overtakes queued data frames
    en = 1'b0;
    for (int i = 0; i < 5; i++) push(27'h100000 + 27'(i));
    chk("prio.level5", {28'b0, lvl}, 32'd5);
    en = 1'b1;
    wait_start(27'h100000, "prio.d0");
    cv = 1'b1; cd = 27'h1BC_00_55;
    step();
    cv = 1'b0;
    chk("prio.ctl_ready_busy", {31'b0, crdy}, 32'd0);
    chk("prio.level4", {28'b0, lvl}, 32'd4);
    do_eot(10, "prio.d0");
    wait_start(27'h1BC_00_55, "prio.ctl");
    do_eot(10, "prio.ctl");
    for (int i = 1; i < 5; i++) begin
      wait_start(27'h100000 + 27'(i), $sformatf("prio.d%0d", i));
      do_eot(10, $sformatf("prio.d%0d", i));
    end
    repeat (4) step();
    chk("prio.level0", {28'b0, lvl}, 32'd0);

    // Full FIFO: ready drops, extra push ignored, exactly DEPTH frames drain
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fr[i] = 27'h2A0000 + 27'(i * 3);
      push(fr[i]);
    end
    chk("full.level8", {28'b0, lvl}, 32'd8);
    chk("full.wr_ready", {31'b0, wrdy}, 32'd0);
    push(27'h7FFFFFF);
    chk("full.ninth_ignored", {28'b0, lvl}, 32'd8);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_start(fr[i], $sformatf("full.f%0d", i));
      do_eot(4, $sformatf("full.f%0d", i));
    end
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (start) n++;
    end
    chk("full.no_extra_start", n, 32'd0);
    chk("full.level_drained", {28'b0, lvl}, 32'd0);
    chk("full.wr_ready_back", {31'b0, wrdy}, 32'd1);

    // Idle fill on the second instance: comma frames with an exact gap
    n = 0;
    while (!b_start && n < WMAX) begin
      step();
      n++;
    end
    chk("fill.first_start", {31'b0, b_start}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fill.data%0d", k), b_sdata, {5'b0, IDLEW});
      repeat (3) step();
      b_eot = 1'b1;
      step();
      b_eot = 1'b0;
      chk($sformatf("fill.sent%0d", k), {16'b0, b_sent}, k + 1);
      n = 0;
      while (!b_start && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("fill.gap%0d", k), n, GAPC + 1);
    end

    // Timeout abort, next frame still launches, clear vs same-cycle timeout
    push(27'h0AAAAA);
    push(27'h0BBBBB);
    wait_start(27'h0AAAAA, "tmo.t1");
    repeat (TMO) step();
    chk("tmo.not_yet", {31'b0, err}, 32'd0);
    step();
    chk("tmo.err_set", {31'b0, err}, 32'd1);
    chk("tmo.sent_unchanged", {16'b0, sent}, exp_sent);
    wait_start(27'h0BBBBB, "tmo.t2");
    repeat (TMO) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("tmo.timeout_beats_clear", {31'b0, err}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("tmo.err_cleared", {31'b0, err}, 32'd0);
    chk("tmo.sent_unchanged2", {16'b0, sent}, exp_sent);
    push(27'h0CCCCC);
    wait_start(27'h0CCCCC, "tmo.t3");
    do_eot(5, "tmo.t3");

    // Reset during WAIT_EOT
    push(27'h0DDDDD);
    push(27'h0EEEEE);
    wait_start(27'h0DDDDD, "rst.r1");
    repeat (3) step();
    chk("rst.busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst.async");
    step();
    rst_n = 1'b1;
    exp_sent = 0;
    step();
    chk("rst.level_after", {28'b0, lvl}, 32'd0);
    chk("rst.sent_after", {16'b0, sent}, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (start) n++;
    end
    chk("rst.no_start_after", n, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
